mem_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch requester and the data (load/store) requester. Sits between the fetch stage / execute-stage memory interface and the memory or cache. It keeps one transaction outstanding on the shared port, buffers one pending request per requester, and routes each response back to its owner. Data requests have priority, with a starvation counter that guarantees instruction-fetch progress.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared memory-port arbiter: data has priority, a starvation counter guarantees
// instruction-fetch progress, one pending slot per requester, responses routed to owner.
package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_I,
    S_BUSY_D
  } state_t;

  state_t     r_state;
  state_t     w_next;
  mem_in_type r_islot;
  mem_in_type r_dslot;
  logic [3:0] r_starve;

  mem_in_type w_icand;
  mem_in_type w_dcand;
  logic       w_grant_en;
  logic       w_starved;
  logic       w_gnt_i;
  logic       w_gnt_d;

  // A live request always wins over the same requester's pending slot.
  always_comb begin
    w_icand    = imem_in.mem_valid ? imem_in : r_islot;
    w_dcand    = dmem_in.mem_valid ? dmem_in : r_dslot;
    w_grant_en = !reset && ((r_state == S_IDLE) || mem_out.mem_ready);
    w_starved  = (r_starve == LP_STARVE_MAX) && w_icand.mem_valid;
    w_gnt_d    = w_grant_en && w_dcand.mem_valid && !w_starved;
    w_gnt_i    = w_grant_en && w_icand.mem_valid && !w_gnt_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_grant_en) begin
      if (w_gnt_d) begin
        w_next = S_BUSY_D;
      end else if (w_gnt_i) begin
        w_next = S_BUSY_I;
      end else begin
        w_next = S_IDLE;
      end
    end
  end

  always_comb begin
    mem_in   = '0;
    imem_out = '0;
    dmem_out = '0;
    if (!reset) begin
      if (w_gnt_d) begin
        mem_in = w_dcand;
      end else if (w_gnt_i) begin
        mem_in = w_icand;
      end
      case (r_state)
        S_BUSY_I: imem_out = mem_out;
        S_BUSY_D: dmem_out = mem_out;
        default:  ;
      endcase
    end
  end

  // Slots: cleared on grant, otherwise the latest live request overwrites.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_islot <= '0;
      r_dslot <= '0;
    end else begin
      if (w_gnt_i) begin
        r_islot <= '0;
      end else if (imem_in.mem_valid) begin
        r_islot <= imem_in;
      end
      if (w_gnt_d) begin
        r_dslot <= '0;
      end else if (dmem_in.mem_valid) begin
        r_dslot <= dmem_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!w_icand.mem_valid || w_gnt_i) begin
      r_starve <= '0;
    end else if (w_gnt_d && (r_starve != LP_STARVE_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, collision, starvation,
// spec redirect, routing isolation and reset mid-transaction.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_in_type  mem_in;
  mem_out_type mem_out;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_i(input logic v, input logic spec, input logic [31:0] a);
    imem_in           = '0;
    imem_in.mem_valid = v;
    imem_in.mem_spec  = spec;
    imem_in.mem_instr = v;
    imem_in.mem_addr  = a;
  endtask

  task automatic drive_d(input logic v, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
    dmem_in           = '0;
    dmem_in.mem_valid = v;
    dmem_in.mem_addr  = a;
    dmem_in.mem_wdata = wd;
    dmem_in.mem_wstrb = ws;
  endtask

  task automatic drive_m(input logic r, input logic [31:0] rd);
    mem_out.mem_ready = r;
    mem_out.mem_rdata = rd;
  endtask

  // Advance past the next rising edge; inputs are then changed and checked mid-cycle.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive_i(1'b1, 1'b0, 32'h4);
    drive_d(1'b1, 32'h8, 32'h0, 4'h0);
    drive_m(1'b1, 32'hCAFE_F00D);
    cyc();
    cyc();
    #1;
    chk("rst_mem_valid", 32'(mem_in.mem_valid), 32'd0);
    chk("rst_mem_addr", mem_in.mem_addr, 32'h0);
    chk("rst_imem_ready", 32'(imem_out.mem_ready), 32'd0);
    chk("rst_dmem_ready", 32'(dmem_out.mem_ready), 32'd0);
    chk("rst_dmem_rdata", dmem_out.mem_rdata, 32'h0);

    // First request after reset goes straight through in idle.
    reset = 1'b0;
    drive_i(1'b0, 1'b0, 32'h0);
    drive_d(1'b1, 32'h100, 32'h0, 4'h0);
    drive_m(1'b0, 32'h0);
    #1;
    chk("idle_d_valid", 32'(mem_in.mem_valid), 32'd1);
    chk("idle_d_addr", mem_in.mem_addr, 32'h100);
    cyc();
    drive_d(1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1'b1, 32'h55);
    #1;
    chk("first_d_ready", 32'(dmem_out.mem_ready), 32'd1);
    chk("first_d_rdata", dmem_out.mem_rdata, 32'h55);
    chk("first_i_ready", 32'(imem_out.mem_ready), 32'd0);
    cyc();
    drive_m(1'b0, 32'h0);

    // Collision in idle: data first, fetch issued on data's ready cycle.
    drive_i(1'b1, 1'b0, 32'h0);
    drive_d(1'b1, 32'h2000, 32'h0, 4'h0);
    #1;
    chk("coll_grant_addr", mem_in.mem_addr, 32'h2000);
    chk("coll_grant_instr", 32'(mem_in.mem_instr), 32'd0);
    cyc();
    drive_i(1'b0, 1'b0, 32'h0);
    drive_d(1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("coll_wait_valid", 32'(mem_in.mem_valid), 32'd0);
      chk("coll_wait_iready", 32'(imem_out.mem_ready), 32'd0);
      cyc();
    end
    drive_m(1'b1, 32'hAAAA);
    #1;
    chk("coll_d_ready", 32'(dmem_out.mem_ready), 32'd1);
    chk("coll_i_ready0", 32'(imem_out.mem_ready), 32'd0);
    chk("coll_i_issue_valid", 32'(mem_in.mem_valid), 32'd1);
    chk("coll_i_issue_addr", mem_in.mem_addr, 32'h0);
    chk("coll_i_issue_instr", 32'(mem_in.mem_instr), 32'd1);
    cyc();
    drive_m(1'b1, 32'h1234);
    #1;
    chk("coll_i_ready", 32'(imem_out.mem_ready), 32'd1);
    chk("coll_i_rdata", imem_out.mem_rdata, 32'h1234);
    chk("coll_d_ready0", 32'(dmem_out.mem_ready), 32'd0);
    chk("coll_after_valid", 32'(mem_in.mem_valid), 32'd0);
    cyc();
    drive_m(1'b0, 32'h0);

    // Starvation: four data grants while fetch waits, then fetch, then data again.
    drive_i(1'b1, 1'b0, 32'h300);
    drive_d(1'b1, 32'h400, 32'h0, 4'h0);
    #1;
    chk("starve_g1", mem_in.mem_addr, 32'h400);
    cyc();
    drive_i(1'b0, 1'b0, 32'h0);
    drive_m(1'b1, 32'h0);
    for (int k = 1; k < 4; k++) begin
      drive_d(1'b1, 32'h400 + 32'(4 * k), 32'h0, 4'h0);
      #1;
      chk("starve_dgrant", mem_in.mem_addr, 32'h400 + 32'(4 * k));
      chk("starve_dinstr", 32'(mem_in.mem_instr), 32'd0);
      cyc();
    end
    drive_d(1'b1, 32'h410, 32'h0, 4'h0);
    #1;
    chk("starve_igrant_addr", mem_in.mem_addr, 32'h300);
    chk("starve_igrant_instr", 32'(mem_in.mem_instr), 32'd1);
    cyc();
    drive_d(1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1'b1, 32'h3000);
    #1;
    chk("starve_i_rdata", imem_out.mem_rdata, 32'h3000);
    chk("starve_resume_addr", mem_in.mem_addr, 32'h410);
    chk("starve_resume_valid", 32'(mem_in.mem_valid), 32'd1);
    cyc();
    #1;
    chk("starve_last_dready", 32'(dmem_out.mem_ready), 32'd1);
    chk("starve_last_valid", 32'(mem_in.mem_valid), 32'd0);
    cyc();
    drive_m(1'b0, 32'h0);

    // Spec redirect: outstanding fetch still completes, redirect issued next.
    drive_i(1'b1, 1'b0, 32'h40);
    #1;
    chk("spec_first_addr", mem_in.mem_addr, 32'h40);
    cyc();
    drive_i(1'b1, 1'b1, 32'h80);
    #1;
    chk("spec_busy_valid", 32'(mem_in.mem_valid), 32'd0);
    cyc();
    drive_i(1'b0, 1'b0, 32'h0);
    drive_m(1'b1, 32'h4040);
    #1;
    chk("spec_old_ready", 32'(imem_out.mem_ready), 32'd1);
    chk("spec_old_rdata", imem_out.mem_rdata, 32'h4040);
    chk("spec_new_addr", mem_in.mem_addr, 32'h80);
    chk("spec_new_spec", 32'(mem_in.mem_spec), 32'd1);
    cyc();
    drive_m(1'b1, 32'h8080);
    #1;
    chk("spec_new_rdata", imem_out.mem_rdata, 32'h8080);
    cyc();
    drive_m(1'b0, 32'h0);

    // Routing isolation on a data store.
    drive_d(1'b1, 32'h500, 32'h11, 4'hF);
    #1;
    chk("store_wstrb", 32'(mem_in.mem_wstrb), 32'hF);
    chk("store_wdata", mem_in.mem_wdata, 32'h11);
    cyc();
    drive_d(1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1'b1, 32'hDEADBEEF);
    #1;
    chk("iso_d_ready", 32'(dmem_out.mem_ready), 32'd1);
    chk("iso_d_rdata", dmem_out.mem_rdata, 32'hDEADBEEF);
    chk("iso_i_ready", 32'(imem_out.mem_ready), 32'd0);
    chk("iso_i_rdata", imem_out.mem_rdata, 32'h0);
    cyc();
    drive_m(1'b0, 32'h0);

    // Reset while busy_d with the fetch slot full.
    drive_i(1'b1, 1'b0, 32'h700);
    drive_d(1'b1, 32'h600, 32'h0, 4'h0);
    #1;
    chk("mid_grant_addr", mem_in.mem_addr, 32'h600);
    cyc();
    drive_i(1'b0, 1'b0, 32'h0);
    drive_d(1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_slot_cleared", 32'(mem_in.mem_valid), 32'd0);
    drive_m(1'b1, 32'h99);
    #1;
    chk("mid_late_dready", 32'(dmem_out.mem_ready), 32'd0);
    chk("mid_late_iready", 32'(imem_out.mem_ready), 32'd0);
    chk("mid_late_valid", 32'(mem_in.mem_valid), 32'd0);
    cyc();
    drive_m(1'b0, 32'h0);
    #1;
    chk("mid_still_idle", 32'(mem_in.mem_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
